// File: rtl/scan_cfg_pkg.sv
// Shared types, constants and helpers for the fabric configuration scan loader.
package scan_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_WORD = 2'd1,
        SHIFT     = 2'd2,
        FINISH    = 2'd3
    } scan_cfg_state_t;

    // One CLB: 1 mode bit + 12 connection-select bits + 16 LUT bits.
    localparam int CLB_CHAIN_LEN = 29;

    function automatic int num_words(input int chain_len, input int word_width);
        return (chain_len + word_width - 1) / word_width;
    endfunction

endpackage

// File: rtl/scan_cfg_serializer.sv
// Parallel-load, shift-right register that tracks how many bits of the current word have moved.
module scan_cfg_serializer
    import scan_cfg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    input  logic             shift_in,
    output logic [WIDTH-1:0] q,
    output logic [BW-1:0]    bit_cnt,
    output logic             last
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q       <= '0;
            bit_cnt <= '0;
        end else if (clr) begin
            q       <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            q       <= load_data;
            bit_cnt <= '0;
        end else if (shift) begin
            q       <= {shift_in, q[WIDTH-1:1]};
            bit_cnt <= bit_cnt + BW'(1);
        end
    end

    // High while the bit at q[0] is the final bit of the current word.
    assign last = (bit_cnt == BW'(WIDTH - 1));

endmodule

// File: rtl/scan_config_loader.sv
// Serializes a word-wide host stream into the fabric configuration scan chain.
// Define SCAN_READBACK_EN to capture the bits leaving the chain tail as readback words.
module scan_config_loader
    import scan_cfg_pkg::*;
#(
    parameter int CHAIN_LEN  = CLB_CHAIN_LEN,
    parameter int WORD_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] cfg_data,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic                  scan_data,
    output logic                  scan_en,
    input  logic                  chain_tail,
    output logic                  busy,
    output logic                  done,
    output logic [WORD_WIDTH-1:0] rb_data,
    output logic                  rb_valid
);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_WAIT   = WAIT_WORD;
    localparam logic [1:0] S_SHIFT  = SHIFT;
    localparam logic [1:0] S_FINISH = FINISH;
    localparam int BW = $clog2(WORD_WIDTH + 1);

    // Host handshake: a word transfers on a rising edge where cfg_valid && cfg_ready;
    // cfg_ready is registered and high only in WAIT_WORD, so nothing depends on cfg_valid combinationally.
    logic [1:0]            state;
    logic [CNT_WIDTH-1:0]  bit_cnt;
    logic                  hs;
    logic                  in_shift;
    logic                  final_bit;
    logic [WORD_WIDTH-1:0] tx_q;
    logic [BW-1:0]         tx_cnt;
    logic                  tx_last;
    logic                  unused_tx_hi;

    assign hs           = cfg_valid && cfg_ready;
    assign in_shift     = (state == S_SHIFT);
    assign final_bit    = in_shift && (bit_cnt == CNT_WIDTH'(CHAIN_LEN - 1));
    assign scan_data    = tx_q[0];
    assign unused_tx_hi = ^{tx_q[WORD_WIDTH-1:1], tx_cnt};

    // Cleared after the final bit so leftover upper bits of the last word never reach scan_data.
    scan_cfg_serializer #(.WIDTH(WORD_WIDTH)) u_tx (
        .clk       (clk),
        .rst       (rst),
        .clr       (final_bit),
        .load      (hs),
        .load_data (cfg_data),
        .shift     (in_shift),
        .shift_in  (1'b0),
        .q         (tx_q),
        .bit_cnt   (tx_cnt),
        .last      (tx_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            cfg_ready <= 1'b0;
            scan_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_WAIT;
                        bit_cnt   <= '0;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (hs) begin
                        state     <= S_SHIFT;
                        cfg_ready <= 1'b0;
                        scan_en   <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    bit_cnt <= bit_cnt + CNT_WIDTH'(1);
                    if (final_bit) begin
                        state   <= S_FINISH;
                        scan_en <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (tx_last) begin
                        state     <= S_WAIT;
                        scan_en   <= 1'b0;
                        cfg_ready <= 1'b1;
                    end
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

`ifdef SCAN_READBACK_EN
    logic [WORD_WIDTH-1:0] rb_q;
    logic [WORD_WIDTH-1:0] rb_next;
    logic [BW-1:0]         rb_cnt;
    logic                  rb_last;
    logic                  rb_emit;

    // Tail bits enter at the MSB; a short final word is right-aligned so it comes out zero-padded.
    assign rb_next = {chain_tail, rb_q[WORD_WIDTH-1:1]};
    assign rb_emit = scan_en && (rb_last || final_bit);

    scan_cfg_serializer #(.WIDTH(WORD_WIDTH)) u_rb (
        .clk       (clk),
        .rst       (rst),
        .clr       (rb_emit),
        .load      (1'b0),
        .load_data ('0),
        .shift     (scan_en),
        .shift_in  (chain_tail),
        .q         (rb_q),
        .bit_cnt   (rb_cnt),
        .last      (rb_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= rb_emit;
            if (rb_emit)
                rb_data <= rb_next >> (WORD_WIDTH - 1 - int'(rb_cnt));
        end
    end
`else
    logic unused_tail;
    assign unused_tail = chain_tail;
    assign rb_data     = '0;
    assign rb_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_scan_config_loader.sv
// Self-checking bench for scan_config_loader with a 29-deep scan chain model.
`timescale 1ns/1ps
module tb_scan_config_loader;
    import scan_cfg_pkg::*;

    localparam int CHAIN_LEN = CLB_CHAIN_LEN;
    localparam int W         = 8;
    localparam int NW        = num_words(CHAIN_LEN, W);
    localparam logic [31:0] BASIC_IMG = 32'h15FF3CA5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [W-1:0] cfg_data = '0;
    logic         cfg_ready, scan_data, scan_en, busy, done, rb_valid;
    logic         chain_tail;
    logic [W-1:0] rb_data;
    logic [CHAIN_LEN-1:0] chain = '0;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, en_cnt = 0, done_cnt = 0, hs_cnt = 0, rb_cnt = 0, ready_seen = 0, done_cyc = 0;
    bit rb_check = 1'b0;
    logic [0:0]   exp_q[$];
    logic [W-1:0] rb_exp_q[$];

    scan_config_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_WIDTH(W), .CNT_WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_data   (cfg_data),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .scan_data  (scan_data),
        .scan_en    (scan_en),
        .chain_tail (chain_tail),
        .busy       (busy),
        .done       (done),
        .rb_data    (rb_data),
        .rb_valid   (rb_valid)
    );

    // ---------------- clock / chain model ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (scan_en) chain <= {chain[CHAIN_LEN-2:0], scan_data};
    assign chain_tail = chain[CHAIN_LEN-1];
    always @(posedge clk) if (!rst && cfg_valid && cfg_ready) hs_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (scan_en) begin
                en_cnt++;
                if (exp_q.size() == 0) check("scan_en_extra", scan_en, 1'b0);
                else                   check("scan_bit", scan_data, exp_q.pop_front());
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_at_done", busy, 1'b0);
            end
            if (cfg_ready) ready_seen++;
            if (rb_valid) begin
                rb_cnt++;
                if (rb_check) begin
                    if (rb_exp_q.size() == 0) check("rb_extra", rb_valid, 1'b0);
                    else                      check("rb_word", rb_data, rb_exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send_word(input logic [W-1:0] d, input int stall);
        int k;
        k = 0;
        cfg_data  = d;
        cfg_valid = (stall == 0);
        @(negedge clk);
        while (!cfg_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("ready_timeout", k < 100, 1'b1);
        repeat (stall) @(negedge clk);
        cfg_valid = 1'b1;
        @(posedge clk);
        #1 cfg_valid = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] img, input int stall_word, input int stall_len,
                           input bit poke_start, input string tag);
        int en0, hs0, d0, c0, k, extra;
        @(posedge clk);
        #1;
        en0 = en_cnt; hs0 = hs_cnt; d0 = done_cnt; c0 = cyc;
        extra = (stall_word >= 0 && stall_word < NW) ? stall_len : 0;
        for (int i = 0; i < CHAIN_LEN; i++) exp_q.push_back(img[i]);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check({tag, "_busy"}, busy, 1'b1);
        for (int w = 0; w < NW; w++) begin
            send_word(img[w*W +: W], (w == stall_word) ? stall_len : 0);
            if (poke_start && w == 1) begin
                @(negedge clk) start = 1'b1;
                @(negedge clk) start = 1'b0;
            end
        end
        k = 0;
        while (done_cnt == d0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        check({tag, "_latency"}, done_cyc - c0, CHAIN_LEN + NW + 1 + extra);
        check({tag, "_en_cycles"}, en_cnt - en0, CHAIN_LEN);
        check({tag, "_handshakes"}, hs_cnt - hs0, NW);
        check({tag, "_done_pulses"}, done_cnt - d0, 1);
        check({tag, "_bits_left"}, exp_q.size(), 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int en0, hs0, rb0, k;
        #12;
        check("rst_cfg_ready", cfg_ready, 1'b0);
        check("rst_scan_data", scan_data, 1'b0);
        check("rst_scan_en", scan_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rb_valid", rb_valid, 1'b0);
        check("rst_rb_data", rb_data, 8'h00);
        @(posedge clk);
        #1 rst = 1'b0;
        ready_seen = 0;
        repeat (5) @(negedge clk);
        check("idle_no_ready", ready_seen, 0);

        do_load(BASIC_IMG, -1, 0, 1'b0, "basic");
        do_load(BASIC_IMG, 2, 3, 1'b0, "stall");
        do_load($urandom(), -1, 0, 1'b1, "poke_start");

        // A word offered while idle must never be taken.
        hs0 = hs_cnt;
        ready_seen = 0;
        cfg_data  = 8'h77;
        cfg_valid = 1'b1;
        repeat (20) @(negedge clk);
        cfg_valid = 1'b0;
        check("extra_word_ready", ready_seen, 0);
        check("extra_word_hs", hs_cnt - hs0, 0);

        // Reset in the middle of the second word.
        en0 = en_cnt;
        for (int i = 0; i < CHAIN_LEN; i++) exp_q.push_back(BASIC_IMG[i]);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        send_word(8'hA5, 0);
        send_word(8'h3C, 0);
        k = 0;
        while (en_cnt - en0 < 10 && k < 100) begin
            @(negedge clk);
            k++;
        end
        #2 rst = 1'b1;
        #1;
        check("midrst_scan_en", scan_en, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_cfg_ready", cfg_ready, 1'b0);
        check("midrst_scan_data", scan_data, 1'b0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        do_load(BASIC_IMG, -1, 0, 1'b0, "after_rst");

`ifdef SCAN_READBACK_EN
        do_load(BASIC_IMG, -1, 0, 1'b0, "rb_image");
        rb_exp_q = {8'hA5, 8'h3C, 8'hFF, 8'h15};
        rb0 = rb_cnt;
        rb_check = 1'b1;
        do_load(32'h0, -1, 0, 1'b0, "rb_zero");
        rb_check = 1'b0;
        check("rb_pulses", rb_cnt - rb0, NW);
        check("rb_words_left", rb_exp_q.size(), 0);
`else
        rb0 = rb_cnt;
        check("rb_never_valid", rb0, 0);
        check("rb_data_zero", rb_data, 8'h00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
